// File: rtl/data_mem_responder.sv
// Memory-side responder for EX-stage loads/stores: fixed-latency handshake on a
// word-organised data RAM with RV32I byte/half/word lanes and sign/zero extension.
module data_mem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 3
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              mem_ready,
  output logic [31:0]       rdata,
  output logic              misaligned
);

  // state | meaning
  // IDLE  | waiting for memRead/memWrite; request accepted at the next edge
  // BUSY  | access in flight, mem_ready low, cnt counts down to 0
  // DONE  | one-cycle completion window, requests ignored
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam int WORDS = 2 ** (ADDR_W - 2);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_load_q, op_load_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                mis_q, mis_d;

  logic [31:0]         mem [WORDS];
  logic [ADDR_W-3:0]   word_idx;
  logic [31:0]         rd_word, wr_word, load_val;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;
  logic                legal, bad, exec, mem_we;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_load_q <= 1'b0;
      addr_q    <= '0;
      funct3_q  <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_load_q <= op_load_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      mis_q     <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (memRead || memWrite) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_ready  = (state_q != BUSY);
    rdata      = rdata_q;
    misaligned = mis_q;
  end

  // Access decode works only on the latched request.
  always_comb begin
    word_idx = addr_q[ADDR_W-1:2];
    rd_word  = mem[word_idx];
    legal    = (funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    bad      = !legal
               || (funct3_q[1:0] == 2'b01 && addr_q[0])
               || (funct3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    byte_sel = rd_word[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = rd_word;
    endcase

    wr_word = rd_word;
    case (funct3_q[1:0])
      2'b00:   wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: wr_word = wdata_q;
    endcase

    exec   = (state_q == BUSY) && (cnt_q == 4'd0);
    mem_we = exec && !op_load_q && !bad;
  end

  always_comb begin
    cnt_d     = cnt_q;
    op_load_d = op_load_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mis_d     = mis_q;
    if (state_q == IDLE && (memRead || memWrite)) begin
      cnt_d     = 4'(LATENCY - 1);
      op_load_d = memRead;
      addr_d    = addr;
      funct3_d  = funct3;
      wdata_d   = wdata;
    end else if (state_q == BUSY && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (exec) begin
      mis_d = bad;
      if (op_load_q) rdata_d = bad ? 32'd0 : load_val;
    end
  end

  // No reset on the array: contents survive rstN.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= wr_word;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised + directed bench for data_mem_responder, one instance at LATENCY=3 and
// one at LATENCY=1, checked against a byte-addressed reference memory.
module tb_data_mem_responder;

  logic        clk, rstN;
  logic        mem_read0, mem_write0, mem_read1, mem_write1;
  logic [2:0]  funct3_0, funct3_1;
  logic [11:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        mem_ready0, mem_ready1, mis0, mis1;
  logic [31:0] rdata0, rdata1;

  int          n_err, n_chk;
  logic [7:0]  ref_b [2][4096];
  logic [31:0] exp_rdata [2];
  logic        exp_mis [2];

  data_mem_responder #(.ADDR_W(12), .LATENCY(3)) u_dut3 (
    .clk(clk), .rstN(rstN), .memRead(mem_read0), .memWrite(mem_write0),
    .funct3(funct3_0), .addr(addr0), .wdata(wdata0),
    .mem_ready(mem_ready0), .rdata(rdata0), .misaligned(mis0));

  data_mem_responder #(.ADDR_W(12), .LATENCY(1)) u_dut1 (
    .clk(clk), .rstN(rstN), .memRead(mem_read1), .memWrite(mem_write1),
    .funct3(funct3_1), .addr(addr1), .wdata(wdata1),
    .mem_ready(mem_ready1), .rdata(rdata1), .misaligned(mis1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 3 : 1;
  endfunction

  function automatic logic get_ready(input int idx);
    return (idx == 0) ? mem_ready0 : mem_ready1;
  endfunction

  function automatic logic [31:0] get_rdata(input int idx);
    return (idx == 0) ? rdata0 : rdata1;
  endfunction

  function automatic logic get_mis(input int idx);
    return (idx == 0) ? mis0 : mis1;
  endfunction

  task automatic drive(input int idx, input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [11:0] a, input logic [31:0] wd);
    if (idx == 0) begin
      mem_read0 = rd; mem_write0 = wr; funct3_0 = f3; addr0 = a; wdata0 = wd;
    end else begin
      mem_read1 = rd; mem_write1 = wr; funct3_1 = f3; addr1 = a; wdata1 = wd;
    end
  endtask

  // Reference: byte-addressed little-endian memory, RV32I width rules.
  task automatic model_access(input int idx, input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [11:0] a, input logic [31:0] wd);
    int          size;
    bit          bad;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    bad  = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
           || (int'(a) % size != 0);
    exp_mis[idx] = bad;
    if (rd) begin
      if (bad) exp_rdata[idx] = 32'd0;
      else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(ref_b[idx][int'(a) + i]) << (8 * i));
        if (f3[2] == 1'b0 && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (f3[2] == 1'b0 && size == 2 && v[15]) v = v | 32'hFFFF_0000;
        exp_rdata[idx] = v;
      end
    end else if (wr && !bad) begin
      for (int i = 0; i < size; i++) ref_b[idx][int'(a) + i] = 8'((wd >> (8 * i)) & 32'hFF);
    end
  endtask

  task automatic do_access(input int idx, input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [11:0] a, input logic [31:0] wd);
    int lows;
    @(negedge clk);
    drive(idx, rd, wr, f3, a, wd);
    @(posedge clk); #1;
    drive(idx, 0, 0, 3'd0, 12'd0, 32'd0);
    lows = 0;
    while (get_ready(idx) == 1'b0 && lows < 40) begin
      lows++;
      @(posedge clk); #1;
    end
    check("latency", lows, lat_of(idx));
    model_access(idx, rd, wr, f3, a, wd);
    check("rdata", get_rdata(idx), exp_rdata[idx]);
    check("misaligned", 32'(get_mis(idx)), 32'(exp_mis[idx]));
    @(posedge clk); #1;
  endtask

  task automatic prefill(input int idx);
    for (int w = 0; w < 16; w++) do_access(idx, 0, 1, 3'b010, 12'(12'h040 + 4 * w), $urandom);
  endtask

  task automatic random_ops(input int idx, input int n);
    int          r;
    bit          rd, wr;
    for (int k = 0; k < n; k++) begin
      r  = int'($urandom_range(0, 3));
      rd = (r != 2);
      wr = (r >= 2);
      do_access(idx, rd, wr, 3'($urandom_range(0, 7)), 12'(12'h040 + $urandom_range(0, 63)),
                $urandom);
    end
  endtask

  initial begin
    logic [31:0] pat, exp_pat;
    n_err = 0;
    n_chk = 0;
    rstN  = 1'b0;
    drive(0, 0, 0, 3'd0, 12'd0, 32'd0);
    drive(1, 0, 0, 3'd0, 12'd0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      exp_rdata[i] = 32'd0;
      exp_mis[i]   = 1'b0;
    end
    #1;
    check("rst_ready3", 32'(mem_ready0), 32'd1);
    check("rst_rdata3", rdata0, 32'd0);
    check("rst_mis3", 32'(mis0), 32'd0);
    check("rst_ready1", 32'(mem_ready1), 32'd1);
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    // Directed sequence on the LATENCY=3 instance.
    do_access(0, 0, 1, 3'b010, 12'h010, 32'hDEAD_BEEF);
    do_access(0, 1, 0, 3'b010, 12'h010, 32'd0);
    check("lw_deadbeef", rdata0, 32'hDEAD_BEEF);
    do_access(0, 0, 1, 3'b000, 12'h011, 32'h0000_0080);
    do_access(0, 1, 0, 3'b010, 12'h010, 32'd0);
    check("sb_merge", rdata0, 32'hDEAD_80EF);
    do_access(0, 1, 0, 3'b000, 12'h011, 32'd0);
    check("lb_sign", rdata0, 32'hFFFF_FF80);
    do_access(0, 1, 0, 3'b100, 12'h011, 32'd0);
    check("lbu_zero", rdata0, 32'h0000_0080);
    do_access(0, 1, 0, 3'b001, 12'h013, 32'd0);
    do_access(0, 0, 1, 3'b010, 12'h012, 32'h1111_2222);
    do_access(0, 1, 0, 3'b010, 12'h010, 32'd0);
    do_access(0, 1, 0, 3'b011, 12'h010, 32'd0);
    do_access(0, 1, 1, 3'b010, 12'h010, 32'h1234_5678);
    do_access(0, 1, 0, 3'b010, 12'h010, 32'd0);
    do_access(0, 1, 0, 3'b101, 12'h012, 32'd0);

    // memRead held through DONE: DONE and IDLE high, then a second access.
    @(negedge clk);
    drive(0, 1, 0, 3'b010, 12'h010, 32'd0);
    pat = '0;
    exp_pat = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      pat[k] = mem_ready0;
      if (k == 5) drive(0, 0, 0, 3'd0, 12'd0, 32'd0);
      if ((k % 5) >= 3) exp_pat[k] = 1'b1;
    end
    check("held_read_pattern", pat, exp_pat);
    model_access(0, 1, 0, 3'b010, 12'h010, 32'd0);
    model_access(0, 1, 0, 3'b010, 12'h010, 32'd0);
    check("held_read_rdata", rdata0, exp_rdata[0]);

    prefill(0);
    random_ops(0, 60);

    // Reset in the 2nd BUSY cycle of a store aborts it.
    do_access(0, 0, 1, 3'b010, 12'h020, 32'hCAFE_0020);
    do_access(0, 1, 0, 3'b010, 12'h020, 32'd0);
    do_access(0, 0, 1, 3'b010, 12'h022, 32'h5555_5555);
    @(negedge clk);
    drive(0, 0, 1, 3'b010, 12'h020, 32'h0BAD_F00D);
    @(posedge clk); #1;
    drive(0, 0, 0, 3'd0, 12'd0, 32'd0);
    check("busy_cycle1", 32'(mem_ready0), 32'd0);
    @(posedge clk); #1;
    check("busy_cycle2", 32'(mem_ready0), 32'd0);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    check("midrst_ready", 32'(mem_ready0), 32'd1);
    check("midrst_rdata", rdata0, 32'd0);
    check("midrst_mis", 32'(mis0), 32'd0);
    #1;
    rstN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_rdata[i] = 32'd0;
      exp_mis[i]   = 1'b0;
    end
    do_access(0, 1, 0, 3'b010, 12'h020, 32'd0);
    check("aborted_store", rdata0, 32'hCAFE_0020);

    // LATENCY=1 instance.
    do_access(1, 0, 1, 3'b010, 12'h010, 32'hDEAD_BEEF);
    do_access(1, 0, 1, 3'b000, 12'h011, 32'h0000_0080);
    do_access(1, 1, 0, 3'b010, 12'h010, 32'd0);
    check("lat1_sb_merge", rdata1, 32'hDEAD_80EF);
    do_access(1, 1, 0, 3'b001, 12'h012, 32'd0);
    do_access(1, 1, 0, 3'b001, 12'h011, 32'd0);
    prefill(1);
    random_ops(1, 30);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
